// File: rtl/sram_cmd_scheduler.sv
// rtl/sram_cmd_scheduler.sv - command FIFO and paced read/write issue sequencer in front of the SRAM controller
// Optional issue statistics counters are enabled by defining SRAM_SCHED_STATS_EN.
module sram_cmd_scheduler #(
  parameter int DEPTH     = 4,
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int ISSUE_GAP = 3,
  parameter int RD_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [AW-1:0]              cmd_addr,
  input  logic [DW-1:0]              cmd_wdata,
  output logic                       rsp_valid,
  output logic [AW-1:0]              rsp_addr,
  output logic [DW-1:0]              rsp_rdata,
  output logic                       sram_rd_req,
  output logic                       sram_wr_req,
  output logic [AW-1:0]              sram_addr,
  output logic [DW-1:0]              sram_wdata,
  input  logic [DW-1:0]              sram_rdata,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                stat_rd_cnt,
  output logic [15:0]                stat_wr_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(ISSUE_GAP + 1);
  localparam int EW = 1 + AW + DW;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  state_t        state;
  logic          op_we;
  logic [CW-1:0] gap_cnt;
  logic [CW-1:0] rd_wait;
  logic          push;
  logic          pop;

  // Full blocks pushes even when a pop is happening in the same cycle.
  assign cmd_ready  = (level < LW'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_IDLE) && (level != '0);
  assign head       = mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_we, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Request strobes are loaded on the pop edge so they are high exactly during ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_we       <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      sram_rd_req <= 1'b0;
      sram_wr_req <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      sram_rd_req <= 1'b0;
      sram_wr_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            {op_we, sram_addr, sram_wdata} <= head;
            sram_rd_req <= ~head[EW-1];
            sram_wr_req <= head[EW-1];
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          gap_cnt <= CW'(ISSUE_GAP);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == CW'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RD_LAT never exceeds ISSUE_GAP, so at most one read is ever awaiting capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_wait   <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == S_ISSUE && !op_we) rd_wait <= CW'(RD_LAT);
      else if (rd_wait != '0)         rd_wait <= rd_wait - 1'b1;
      if (rd_wait == CW'(1)) begin
        rsp_valid <= 1'b1;
        rsp_addr  <= sram_addr;
        rsp_rdata <= sram_rdata;
      end
    end
  end

`ifdef SRAM_SCHED_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state == S_ISSUE) begin
      if (op_we) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 1'b1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 1'b1;
      end
    end
  end

  assign stat_rd_cnt = rd_cnt_q;
  assign stat_wr_cnt = wr_cnt_q;
`else
  assign stat_rd_cnt = 16'h0000;
  assign stat_wr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_cmd_scheduler.sv
// tb/tb_sram_cmd_scheduler.sv - directed self-checking bench for sram_cmd_scheduler
module tb_sram_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_addr;
  logic [7:0]  rsp_rdata;
  logic        sram_rd_req, sram_wr_req;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdata, sram_rdata;
  logic [2:0]  fifo_level;
  logic [15:0] stat_rd_cnt, stat_wr_cnt;

  logic        use_fixed;
  logic [7:0]  fixed_rdata;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rej;
  int          both_hi = 0;
  int          exp_rd, exp_wr;

  int          ev_cyc[$];
  logic        ev_we[$];
  logic [15:0] ev_addr[$];
  logic [7:0]  ev_wdata[$];
  logic [15:0] rsp_a[$];
  logic [7:0]  rsp_d[$];

  sram_cmd_scheduler dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .sram_rd_req(sram_rd_req), .sram_wr_req(sram_wr_req),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .fifo_level(fifo_level), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data is a fixed pattern of the address unless overridden.
  assign sram_rdata = use_fixed ? fixed_rdata : (sram_addr[7:0] ^ 8'h5A);

  always @(negedge clk) begin
    if (!rst) begin
      if (sram_rd_req || sram_wr_req) begin
        ev_cyc.push_back(cyc);
        ev_we.push_back(sram_wr_req);
        ev_addr.push_back(sram_addr);
        ev_wdata.push_back(sram_wdata);
      end
      if (sram_rd_req && sram_wr_req) both_hi++;
      if (rsp_valid) begin
        rsp_a.push_back(rsp_addr);
        rsp_d.push_back(rsp_rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ev_cyc.delete(); ev_we.delete(); ev_addr.delete(); ev_wdata.delete();
    rsp_a.delete(); rsp_d.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [15:0] a, input logic [7:0] d, output int r);
    r = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && r < 50) begin
      tick();
      r++;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ev(input int n, input string tag);
    int k = 0;
    while (ev_cyc.size() < n && k < 300) begin tick(); k++; end
    check(tag, 32'(ev_cyc.size() >= n), 1);
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k = 0;
    while (rsp_a.size() < n && k < 300) begin tick(); k++; end
    check(tag, 32'(rsp_a.size() >= n), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_req"}, sram_rd_req, 0);
    check({tag, "_wr_req"}, sram_wr_req, 0);
    check({tag, "_addr"},   sram_addr, 0);
    check({tag, "_wdata"},  sram_wdata, 0);
    check({tag, "_rsp_v"},  rsp_valid, 0);
    check({tag, "_rsp_a"},  rsp_addr, 0);
    check({tag, "_rsp_d"},  rsp_rdata, 0);
    check({tag, "_level"},  fifo_level, 0);
    check({tag, "_ready"},  cmd_ready, 1);
    check({tag, "_st_rd"},  stat_rd_cnt, 0);
    check({tag, "_st_wr"},  stat_wr_cnt, 0);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    use_fixed = 1'b0; fixed_rdata = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset");

    // Single read: pulse two cycles after the push cycle, response two after the pulse.
    clr();
    use_fixed = 1'b1; fixed_rdata = 8'hA5;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h1234;
    tick();
    cmd_valid = 1'b0;
    check("sr_level", fifo_level, 1);
    check("sr_req_early", sram_rd_req, 0);
    tick();
    check("sr_rd_req", sram_rd_req, 1);
    check("sr_wr_req", sram_wr_req, 0);
    check("sr_addr", sram_addr, 16'h1234);
    tick();
    check("sr_req_drop", sram_rd_req, 0);
    check("sr_rsp_early", rsp_valid, 0);
    tick();
    check("sr_rsp_valid", rsp_valid, 1);
    check("sr_rsp_addr", rsp_addr, 16'h1234);
    check("sr_rsp_data", rsp_rdata, 8'hA5);
    tick();
    check("sr_rsp_once", rsp_valid, 0);
    check("sr_rsp_hold", rsp_rdata, 8'hA5);
    use_fixed = 1'b0;
    repeat (6) tick();

    // Back-to-back W, R, W.
    clr();
    push(1'b1, 16'h0010, 8'h3C, rej);
    push(1'b0, 16'h0010, 8'h00, rej);
    push(1'b1, 16'h0020, 8'h99, rej);
    wait_ev(3, "b2b_wait");
    repeat (8) tick();
    check("b2b_count", ev_cyc.size(), 3);
    check("b2b_rsp_count", rsp_a.size(), 1);
    if (ev_cyc.size() == 3) begin
      check("b2b_we0", ev_we[0], 1);
      check("b2b_addr0", ev_addr[0], 16'h0010);
      check("b2b_wdata0", ev_wdata[0], 8'h3C);
      check("b2b_we1", ev_we[1], 0);
      check("b2b_addr1", ev_addr[1], 16'h0010);
      check("b2b_we2", ev_we[2], 1);
      check("b2b_addr2", ev_addr[2], 16'h0020);
      check("b2b_wdata2", ev_wdata[2], 8'h99);
      check("b2b_gap01", ev_cyc[1] - ev_cyc[0], 5);
      check("b2b_gap12", ev_cyc[2] - ev_cyc[1], 5);
    end
    if (rsp_a.size() == 1) begin
      check("b2b_rsp_addr", rsp_a[0], 16'h0010);
      check("b2b_rsp_data", rsp_d[0], 8'h4A);
    end

    // Full FIFO: five accepted back to back, sixth rejected on two full cycles.
    clr();
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 16'(16'h0100 + i), 8'(8'h40 + i), rej);
      check("full_rej_early", rej, 0);
    end
    check("full_level", fifo_level, 4);
    check("full_ready", cmd_ready, 0);
    push(1'b1, 16'h0105, 8'h45, rej);
    check("full_rej_count", rej, 2);
    wait_ev(6, "full_wait");
    repeat (8) tick();
    check("full_count", ev_cyc.size(), 6);
    check("full_rsp_none", rsp_a.size(), 0);
    if (ev_cyc.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("full_we", ev_we[i], 1);
        check("full_addr", ev_addr[i], 32'h0100 + i);
        check("full_wdata", ev_wdata[i], 32'h40 + i);
      end
    end

    // Pointer wrap: ten reads in order.
    clr();
    for (int i = 0; i < 10; i++) push(1'b0, 16'(i), 8'h00, rej);
    wait_rsp(10, "wrap_wait");
    repeat (8) tick();
    check("wrap_rsp_count", rsp_a.size(), 10);
    if (rsp_a.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        check("wrap_rsp_addr", rsp_a[i], i);
        check("wrap_rsp_data", rsp_d[i], 32'(8'(i) ^ 8'h5A));
      end
    end

    // Statistics after a clean reset.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    clr();
    push(1'b0, 16'h0030, 8'h00, rej);
    push(1'b1, 16'h0031, 8'h11, rej);
    push(1'b0, 16'h0032, 8'h00, rej);
    push(1'b1, 16'h0033, 8'h22, rej);
    push(1'b0, 16'h0034, 8'h00, rej);
    wait_ev(5, "stat_wait");
    repeat (8) tick();
`ifdef SRAM_SCHED_STATS_EN
    exp_rd = 3; exp_wr = 2;
`else
    exp_rd = 0; exp_wr = 0;
`endif
    check("stat_rd", stat_rd_cnt, exp_rd);
    check("stat_wr", stat_wr_cnt, exp_wr);
    check("req_exclusive", both_hi, 0);

    // Reset mid-WAIT with two entries queued and a read awaiting capture.
    clr();
    push(1'b0, 16'h0200, 8'h00, rej);
    push(1'b1, 16'h0201, 8'h55, rej);
    push(1'b0, 16'h0202, 8'h00, rej);
    check("rw_level", fifo_level, 2);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rw");
    tick();
    rst = 1'b0;
    clr();
    repeat (20) tick();
    check("rw_no_pulse", ev_cyc.size(), 0);
    check("rw_no_rsp", rsp_a.size(), 0);

    // Reset during ISSUE drops the request pulse immediately.
    push(1'b0, 16'h0300, 8'h00, rej);
    tick();
    check("ri_pulse", sram_rd_req, 1);
    rst = 1'b1;
    #1;
    check("ri_drop", sram_rd_req, 0);
    check("ri_addr", sram_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_cmd_scheduler.md
# sram_cmd_scheduler

Command queue and issue sequencer that sits directly upstream of the SRAM controller. It accepts read/write commands from a host over a valid/ready handshake and buffers them in a small FIFO. It presents them one at a time to the controller as single-cycle read/write request pulses with stable address/data, spaced to respect the controller's round-trip. It captures read data and returns it to the host as a one-cycle response.

## Interface
Parameters:
- DEPTH, 4 — FIFO entries; power of 2, ≥2
- AW, 16 — address width
- DW, 8 — data width
- ISSUE_GAP, 3 — cycles spent in WAIT after each issue pulse; ≥1
- RD_LAT, 1 — cycles after the issue cycle at which sram_rdata is sampled; 1 ≤ RD_LAT ≤ ISSUE_GAP

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO can accept: level < DEPTH (combinational from level)
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  AW  command address
- cmd_wdata  in  DW  write data (ignored for reads)
- rsp_valid  out  1  one-cycle read-response strobe; no backpressure
- rsp_addr  out  AW  address of the returned read
- rsp_rdata  out  DW  read data
- sram_rd_req  out  1  to controller read_enable; one-cycle pulse
- sram_wr_req  out  1  to controller write_enable_in; one-cycle pulse
- sram_addr  out  AW  address held from ISSUE until the next ISSUE
- sram_wdata  out  DW  write data held the same way
- sram_rdata  in  DW  data returned from the SRAM path
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- stat_rd_cnt  out  16  issued-read count (see Configuration)
- stat_wr_cnt  out  16  issued-write count (see Configuration)

## Operation
- FIFO:
  - Push on cmd_valid && cmd_ready, storing {we, addr, wdata}.
  - Read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the level unchanged.
  - When full, cmd_ready = 0 even if a pop happens that cycle (no same-cycle refill).
  - A pop never happens when empty.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: if level > 0, pop the head into the issue registers (sram_addr, sram_wdata, op) and go to ISSUE; otherwise stay.
  - ISSUE (exactly 1 cycle): assert sram_rd_req if op = read, else sram_wr_req; load the wait counter with ISSUE_GAP; go to WAIT.
  - WAIT: decrement the counter; on reaching 0 go to IDLE.
- Read capture:
  - sram_rdata is registered on the clock edge ending cycle T+RD_LAT, where T is the ISSUE cycle.
  - rsp_valid = 1 for exactly cycle T+RD_LAT+1, with rsp_addr = sram_addr of that issue.
  - Writes produce no response.
  - rsp_rdata and rsp_addr hold their last values until the next read response.
- sram_rd_req and sram_wr_req are registered, mutually exclusive, and never high outside ISSUE.

## Timing
- Reset values:
  - All registered outputs 0: sram_rd_req, sram_wr_req, sram_addr, sram_wdata, rsp_valid, rsp_addr, rsp_rdata, stat counters.
  - fifo_level = 0, so cmd_ready = 1.
  - State IDLE; pointers 0.
- Command pushed into an empty FIFO at edge E: IDLE pops at E+1, ISSUE occupies cycle E+1..E+2, so the request pulse appears 2 cycles after the push.
- Issue-to-issue spacing is at least ISSUE_GAP+2 cycles (5 by default). This covers the controller's IDLE→READ/WRITE→WAIT→IDLE round-trip.
- Read latency from ISSUE cycle to rsp_valid is RD_LAT+1 cycles (2 by default).
- Reset mid-operation clears all queued and in-flight commands. No response is produced for them; a request pulse in progress drops on the asserting edge.

## Configuration
- Macro SRAM_SCHED_STATS_EN.
- Defined: stat_rd_cnt and stat_wr_cnt increment by 1 in each ISSUE cycle of the matching op and saturate at 16'hFFFF. They clear only on rst.
- Undefined: no counter registers exist; both outputs are tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset: assert rst mid-WAIT with 2 entries queued → all outputs 0, fifo_level = 0, cmd_ready = 1; no rsp_valid and no req pulse afterwards.
- Single read: push read addr 16'h1234; drive sram_rdata = 8'hA5 → sram_rd_req pulses 2 cycles after the push; rsp_valid 2 cycles after the pulse with rsp_addr = 16'h1234, rsp_rdata = 8'hA5.
- Back-to-back: push W(16'h0010, 8'h3C), R(16'h0010), W(16'h0020, 8'h99) on consecutive cycles → three pulses 5 cycles apart in order, with sram_wdata = 8'h3C and 8'h99 on the write pulses; exactly one rsp_valid.
- Full FIFO: hold cmd_valid for 6 cycles starting at empty, DEPTH = 4 → fifo_level reaches 4 and cmd_ready drops. Full-cycle pushes are rejected; after the pop, cmd_ready returns and the next command is accepted. No command is lost or duplicated.
- Pointer wrap: stream 10 reads at addresses 0..9 → responses return in order with rsp_addr 0..9.
- Stats (macro on): issue 3 reads and 2 writes → stat_rd_cnt = 3, stat_wr_cnt = 2. With the macro off, both stay 0.
